// File: rtl/spi_pkg.sv
// Definitions shared by the SPI master and slave: FSM states, default word
// width and the SPI mode constants.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        TRANSFER,
        HOLD
    } spi_state_t;

    localparam int DATA_WIDTH_DEFAULT = 8;

    // Mode 3: clock idles high, data captured on the rising (trailing) edge.
    localparam logic CPOL = 1'b1;
    localparam logic CPHA = 1'b1;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period counter for the SPI clock: emits alternating fall/rise ticks
// every CLK_DIV cycles while enabled, always starting with a falling tick.
module spi_clk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_m,
    input  logic rst,
    input  logic enable,
    output logic tick_fall,
    output logic tick_rise
);

    localparam int CNT_W = $clog2(CLK_DIV + 1);

    logic [CNT_W-1:0] half_cnt;
    logic             rise_next;
    logic             tick;

    assign tick      = enable && (half_cnt == CNT_W'(CLK_DIV - 1));
    assign tick_fall = tick && !rise_next;
    assign tick_rise = tick && rise_next;

    // Held at zero while disabled so every transfer begins from a clean phase.
    always_ff @(posedge clk_m) begin
        if (rst || !enable) begin
            half_cnt  <= '0;
            rise_next <= 1'b0;
        end else if (tick) begin
            half_cnt  <= '0;
            rise_next <= ~rise_next;
        end else begin
            half_cnt  <= half_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/master_spi.sv
// SPI mode-3 master: shifts one DATA_WIDTH word out on mosi (MSB first) while
// shifting a word in from miso, framed by an active-low slave select.
module master_spi
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int CLK_DIV    = 4
) (
    input  logic                  clk_m,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] data_in_master,
    input  logic                  miso,
    output logic                  sclk_m,
    output logic                  ss,
    output logic                  mosi,
    output logic [DATA_WIDTH-1:0] data_out_master,
    output logic                  busy,
    output logic                  done
);

    localparam int BIT_W = $clog2(DATA_WIDTH + 1);

    spi_state_t            state;
    spi_state_t            state_next;
    logic [DATA_WIDTH-1:0] tx_sh;
    logic [DATA_WIDTH-1:0] tx_next;
    logic [DATA_WIDTH-1:0] rx_sh;
    logic [BIT_W-1:0]      bit_cnt;
    logic                  tick_fall;
    logic                  tick_rise;
    logic                  last_bit;
    logic                  accept;
    logic                  sclk_fall;
    logic                  shift_tx;
    logic                  sclk_rise;
    logic                  finish;

    spi_clk_div #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_div (
        .clk_m    (clk_m),
        .rst      (rst),
        .enable   (state != IDLE),
        .tick_fall(tick_fall),
        .tick_rise(tick_rise)
    );

    assign last_bit = (bit_cnt == BIT_W'(DATA_WIDTH - 1));
    assign tx_next  = tx_sh << 1;

    always_ff @(posedge clk_m) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (start)                  state_next = SETUP;
            SETUP:    if (tick_fall)              state_next = TRANSFER;
            TRANSFER: if (tick_rise && last_bit)  state_next = HOLD;
            HOLD:     if (tick_fall || tick_rise) state_next = IDLE;
            default:                              state_next = IDLE;
        endcase
    end

    // The SETUP exit tick is the first falling edge; it only lowers sclk since
    // the MSB is already on mosi from the accept edge.
    always_comb begin
        accept    = 1'b0;
        sclk_fall = 1'b0;
        shift_tx  = 1'b0;
        sclk_rise = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE:     accept = start;
            SETUP:    sclk_fall = tick_fall;
            TRANSFER: begin
                sclk_fall = tick_fall;
                shift_tx  = tick_fall;
                sclk_rise = tick_rise;
            end
            HOLD:     finish = tick_fall || tick_rise;
            default:  ;
        endcase
    end

    always_ff @(posedge clk_m) begin
        if (rst) begin
            sclk_m          <= CPOL;
            ss              <= 1'b1;
            mosi            <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            data_out_master <= '0;
            tx_sh           <= '0;
            rx_sh           <= '0;
            bit_cnt         <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                tx_sh   <= data_in_master;
                rx_sh   <= '0;
                bit_cnt <= '0;
                ss      <= 1'b0;
                mosi    <= data_in_master[DATA_WIDTH-1];
                busy    <= 1'b1;
            end
            if (sclk_fall) begin
                sclk_m <= ~CPOL;
            end
            if (shift_tx) begin
                tx_sh <= tx_next;
                mosi  <= tx_next[DATA_WIDTH-1];
            end
            if (sclk_rise) begin
                sclk_m  <= CPOL;
                rx_sh   <= DATA_WIDTH'({rx_sh, miso});
                bit_cnt <= bit_cnt + BIT_W'(1);
            end
            if (finish) begin
                ss              <= 1'b1;
                mosi            <= 1'b0;
                busy            <= 1'b0;
                done            <= 1'b1;
                data_out_master <= rx_sh;
            end
        end
    end

endmodule

// File: tb/tb_master_spi.sv
// Directed bench for master_spi: a default-parameter instance talking to a
// modelled slave, plus a CLK_DIV=1 instance wired in loopback.
module tb_master_spi;

    logic       clk_m = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] data_in;
    logic       miso;
    logic       sclk_m;
    logic       ss;
    logic       mosi;
    logic [7:0] data_out;
    logic       busy;
    logic       done;

    logic       start_f;
    logic [7:0] data_in_f;
    logic       miso_f;
    logic       sclk_f;
    logic       ss_f;
    logic       mosi_f;
    logic [7:0] data_out_f;
    logic       busy_f;
    logic       done_f;

    int checks = 0;
    int fails  = 0;

    int         done_total    = 0;
    int         accept_total  = 0;
    int         ss_low_run    = 0;
    int         ss_low_last   = 0;
    int         ss_high_run   = 0;
    int         ss_high_last  = 0;
    int         rise_cnt      = 0;
    int         mosi_idle_err = 0;
    int         ssf_low_run   = 0;
    int         ssf_low_last  = 0;
    logic       prev_ss       = 1'b1;
    logic       prev_sclk     = 1'b1;
    logic [7:0] mosi_cap      = 8'h00;
    logic [7:0] slave_sh      = 8'h00;
    logic [7:0] slave_word    = 8'h00;

    int snap;
    int n;

    master_spi dut (
        .clk_m          (clk_m),
        .rst            (rst),
        .start          (start),
        .data_in_master (data_in),
        .miso           (miso),
        .sclk_m         (sclk_m),
        .ss             (ss),
        .mosi           (mosi),
        .data_out_master(data_out),
        .busy           (busy),
        .done           (done)
    );

    master_spi #(
        .DATA_WIDTH(8),
        .CLK_DIV   (1)
    ) dut_fast (
        .clk_m          (clk_m),
        .rst            (rst),
        .start          (start_f),
        .data_in_master (data_in_f),
        .miso           (miso_f),
        .sclk_m         (sclk_f),
        .ss             (ss_f),
        .mosi           (mosi_f),
        .data_out_master(data_out_f),
        .busy           (busy_f),
        .done           (done_f)
    );

    always #5 clk_m = ~clk_m;

    assign miso   = slave_sh[7];
    assign miso_f = mosi_f;

    // Slave model and frame monitor, sampled on the falling clk_m edge.
    always @(negedge clk_m) begin
        if (done === 1'b1) done_total++;
        if (ss === 1'b0) begin
            ss_low_run++;
            if (ss_high_run != 0) ss_high_last = ss_high_run;
            ss_high_run = 0;
        end else if (ss === 1'b1) begin
            ss_high_run++;
            if (ss_low_run != 0) ss_low_last = ss_low_run;
            ss_low_run = 0;
        end
        if (prev_ss === 1'b1 && ss === 1'b0) begin
            accept_total++;
            rise_cnt = 0;
            mosi_cap = 8'h00;
            slave_sh = slave_word;
        end else if (ss === 1'b0 && sclk_m === 1'b1 && prev_sclk === 1'b0) begin
            rise_cnt++;
            mosi_cap = {mosi_cap[6:0], mosi};
            slave_sh = {slave_sh[6:0], 1'b0};
        end
        if (ss === 1'b1 && mosi !== 1'b0) mosi_idle_err++;
        prev_ss   = ss;
        prev_sclk = sclk_m;
        if (ss_f === 1'b0) begin
            ssf_low_run++;
        end else if (ss_f === 1'b1) begin
            if (ssf_low_run != 0) ssf_low_last = ssf_low_run;
            ssf_low_run = 0;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic [7:0] d, input int cycles);
        start   = s;
        data_in = d;
        repeat (cycles) @(posedge clk_m);
        #1;
    endtask

    task automatic waitDone(input string tag, input int limit);
        int k;
        k = 0;
        while (done !== 1'b1 && k < limit) begin
            @(posedge clk_m);
            #1;
            k++;
        end
        checkOutput(tag, {31'd0, done}, 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        data_in   = 8'h00;
        start_f   = 1'b0;
        data_in_f = 8'h00;

        applyStimulus(1'b0, 8'h00, 2);
        checkOutput("rst_ss",   {31'd0, ss},     32'd1);
        checkOutput("rst_sclk", {31'd0, sclk_m}, 32'd1);
        checkOutput("rst_mosi", {31'd0, mosi},   32'd0);
        checkOutput("rst_busy", {31'd0, busy},   32'd0);
        checkOutput("rst_done", {31'd0, done},   32'd0);
        checkOutput("rst_dout", {24'd0, data_out}, 32'h00);
        rst = 1'b0;
        applyStimulus(1'b0, 8'h00, 2);

        $display("[TB] single transfer B2 / 5A");
        slave_word = 8'h5A;
        snap = done_total;
        applyStimulus(1'b1, 8'hB2, 1);
        checkOutput("acc_busy", {31'd0, busy}, 32'd1);
        checkOutput("acc_ss",   {31'd0, ss},   32'd0);
        checkOutput("acc_mosi", {31'd0, mosi}, 32'd1);
        applyStimulus(1'b0, 8'hB2, 1);
        waitDone("single_done", 100);
        checkOutput("single_dout", {24'd0, data_out}, 32'h5A);
        checkOutput("single_mosi_bits", {24'd0, mosi_cap}, 32'hB2);
        checkOutput("single_busy_at_done", {31'd0, busy}, 32'd0);
        checkOutput("single_ss_at_done", {31'd0, ss}, 32'd1);
        applyStimulus(1'b0, 8'h00, 4);
        checkOutput("single_ss_low_len", ss_low_last, 32'd68);
        checkOutput("single_done_count", done_total - snap, 32'd1);
        checkOutput("single_dout_hold", {24'd0, data_out}, 32'h5A);

        $display("[TB] start held high");
        slave_word = 8'h3C;
        snap = accept_total;
        applyStimulus(1'b1, 8'hC3, 1);
        waitDone("held_done1", 100);
        checkOutput("held_accepts_first", accept_total - snap, 32'd1);
        checkOutput("held_busy_at_done", {31'd0, busy}, 32'd0);
        checkOutput("held_dout1", {24'd0, data_out}, 32'h3C);
        applyStimulus(1'b1, 8'hC3, 1);
        checkOutput("held_reaccept_busy", {31'd0, busy}, 32'd1);
        checkOutput("held_reaccept_ss", {31'd0, ss}, 32'd0);
        applyStimulus(1'b0, 8'hC3, 1);
        waitDone("held_done2", 100);
        checkOutput("held_dout2", {24'd0, data_out}, 32'h3C);
        checkOutput("held_gap", ss_high_last, 32'd1);
        checkOutput("held_accepts_total", accept_total - snap, 32'd2);
        applyStimulus(1'b0, 8'h00, 3);

        $display("[TB] back-to-back FF then 00");
        slave_word = 8'h81;
        snap = done_total;
        applyStimulus(1'b1, 8'hFF, 1);
        applyStimulus(1'b0, 8'hFF, 1);
        waitDone("b2b_done1", 100);
        checkOutput("b2b_dout1", {24'd0, data_out}, 32'h81);
        checkOutput("b2b_mosi1", {24'd0, mosi_cap}, 32'hFF);
        slave_word = 8'h96;
        applyStimulus(1'b1, 8'h00, 1);
        applyStimulus(1'b0, 8'h00, 1);
        waitDone("b2b_done2", 100);
        checkOutput("b2b_dout2", {24'd0, data_out}, 32'h96);
        checkOutput("b2b_mosi2", {24'd0, mosi_cap}, 32'h00);
        checkOutput("b2b_gap", ss_high_last, 32'd1);
        applyStimulus(1'b0, 8'h00, 2);
        checkOutput("b2b_done_count", done_total - snap, 32'd2);

        $display("[TB] reset mid-transfer");
        slave_word = 8'hAA;
        applyStimulus(1'b1, 8'h55, 1);
        applyStimulus(1'b0, 8'h55, 1);
        n = 0;
        while (rise_cnt < 3 && n < 200) begin
            applyStimulus(1'b0, 8'h55, 1);
            n++;
        end
        checkOutput("abort_reached_rise3", rise_cnt, 32'd3);
        snap = done_total;
        rst = 1'b1;
        applyStimulus(1'b1, 8'h55, 1);
        checkOutput("abort_ss",   {31'd0, ss},     32'd1);
        checkOutput("abort_sclk", {31'd0, sclk_m}, 32'd1);
        checkOutput("abort_busy", {31'd0, busy},   32'd0);
        checkOutput("abort_done", {31'd0, done},   32'd0);
        checkOutput("abort_mosi", {31'd0, mosi},   32'd0);
        checkOutput("abort_dout", {24'd0, data_out}, 32'h00);
        rst = 1'b0;
        applyStimulus(1'b0, 8'h55, 1);
        checkOutput("abort_start_ignored", {31'd0, busy}, 32'd0);
        applyStimulus(1'b0, 8'h55, 80);
        checkOutput("abort_no_done", done_total - snap, 32'd0);
        slave_word = 8'hE7;
        applyStimulus(1'b1, 8'h69, 1);
        applyStimulus(1'b0, 8'h69, 1);
        waitDone("fresh_done", 100);
        checkOutput("fresh_dout", {24'd0, data_out}, 32'hE7);
        checkOutput("fresh_mosi", {24'd0, mosi_cap}, 32'h69);
        applyStimulus(1'b0, 8'h00, 2);
        checkOutput("fresh_ss_low_len", ss_low_last, 32'd68);

        $display("[TB] CLK_DIV=1 loopback");
        start_f   = 1'b1;
        data_in_f = 8'hA7;
        applyStimulus(1'b0, 8'h00, 1);
        start_f = 1'b0;
        checkOutput("fast_busy", {31'd0, busy_f}, 32'd1);
        applyStimulus(1'b0, 8'h00, 1);
        checkOutput("fast_sclk_t1", {31'd0, sclk_f}, 32'd0);
        applyStimulus(1'b0, 8'h00, 1);
        checkOutput("fast_sclk_t2", {31'd0, sclk_f}, 32'd1);
        applyStimulus(1'b0, 8'h00, 1);
        checkOutput("fast_sclk_t3", {31'd0, sclk_f}, 32'd0);
        applyStimulus(1'b0, 8'h00, 1);
        checkOutput("fast_sclk_t4", {31'd0, sclk_f}, 32'd1);
        n = 0;
        while (done_f !== 1'b1 && n < 50) begin
            applyStimulus(1'b0, 8'h00, 1);
            n++;
        end
        checkOutput("fast_done", {31'd0, done_f}, 32'd1);
        checkOutput("fast_dout", {24'd0, data_out_f}, 32'hA7);
        applyStimulus(1'b0, 8'h00, 2);
        checkOutput("fast_ss_low_len", ssf_low_last, 32'd17);

        checkOutput("mosi_zero_when_idle", mosi_idle_err, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/master_spi.md
MASTER_SPI -- requirements
Module: master_spi

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, giving bits per transfer.
REQ-002 SHALL have parameter CLK_DIV, default 4, giving clk_m cycles per sclk half-period (legal range >=1).
REQ-003 SHALL have port clk_m  input  1  block clock; the block has one clock, and all logic is on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  transfer request, sampled only in IDLE.
REQ-006 SHALL have port data_in_master  input  DATA_WIDTH  word to send, captured when start is accepted.
REQ-007 SHALL have port miso  input  1  serial data from the slave.
REQ-008 SHALL have port sclk_m  output  1  SPI serial clock; idles high.
REQ-009 SHALL have port ss  output  1  slave select, active low.
REQ-010 SHALL have port mosi  output  1  serial data to the slave, MSB first.
REQ-011 SHALL have port data_out_master  output  DATA_WIDTH  last word received.
REQ-012 SHALL have port busy  output  1  high from the cycle after accept until the cycle done is asserted, exclusive.
REQ-013 SHALL have port done  output  1  one-cycle pulse marking transfer completion.

Function
REQ-014 SHALL implement SPI mode 3 (CPOL=1, CPHA=1): mosi changes after sclk_m falling edges; miso is sampled on sclk_m rising edges.
REQ-015 SHALL use FSM states IDLE -> SETUP -> TRANSFER -> HOLD -> IDLE, all registered.
REQ-016 IDLE with start=1 SHALL, on that edge: load the tx shift register from data_in_master; drive ss=0 and mosi=data_in_master[MSB]; set busy=1; enter SETUP.
REQ-017 SETUP SHALL last CLK_DIV cycles with sclk_m high; its exit edge drives sclk_m low (first falling edge) and enters TRANSFER.
REQ-018 In TRANSFER, sclk_m SHALL toggle every CLK_DIV cycles.
REQ-019 On each rising toggle, TRANSFER SHALL shift miso into the rx register LSB and increment the bit counter.
REQ-020 On each falling toggle except the first, TRANSFER SHALL shift tx left and drive the next bit on mosi.
REQ-021 On the DATA_WIDTH-th rising toggle, the FSM SHALL enter HOLD with sclk_m held high.
REQ-022 HOLD SHALL last CLK_DIV cycles; its exit edge SHALL drive ss=1, load data_out_master from rx, pulse done=1, drive busy=0 and enter IDLE.
REQ-023 ss SHALL stay low for exactly (2*DATA_WIDTH+1)*CLK_DIV cycles (68 at the defaults).
REQ-024 start while not IDLE, including the done cycle, SHALL be ignored; requests are not queued.
REQ-025 The minimum ss-high gap between transfers SHALL be 1 cycle (start asserted in the cycle after done).
REQ-026 data_out_master SHALL change only at done and SHALL otherwise hold its value.
REQ-027 The bit counter SHALL be $clog2(DATA_WIDTH+1) bits wide; the half-period counter SHALL be $clog2(CLK_DIV+1) bits wide and SHALL never wrap outside the SETUP, TRANSFER and HOLD states.
REQ-028 mosi SHALL be 0 whenever ss=1.

Reset
REQ-029 rst=1 SHALL force, on the next clk_m edge, the following values regardless of state: state=IDLE, ss=1, sclk_m=1, mosi=0, busy=0, done=0, data_out_master=0, shift registers and counters=0.
REQ-030 rst asserted mid-transfer SHALL abort the transfer with no done pulse; start coincident with rst SHALL be ignored.

Structure
REQ-031 Package spi_pkg SHALL hold the FSM state enum, the DATA_WIDTH default and the SPI mode constants (CPOL/CPHA), shared with slave_spi.
REQ-032 The half-period counter and sclk toggle generation SHALL be a single sub-module, spi_clk_div (inputs clk_m, rst, enable; outputs tick_fall and tick_rise); all remaining logic SHALL be in master_spi.

Verification
REQ-033 Reset: hold rst for 2 cycles -> ss=1, sclk_m=1, mosi=0, busy=0, done=0, data_out_master=0.
REQ-034 Single transfer: data_in_master=8'b10110010, miso model returns 8'h5A -> mosi at the 8 rising edges is 1,0,1,1,0,0,1,0; data_out_master=8'h5A; exactly one done pulse; ss low for 68 cycles.
REQ-035 Start held high for the whole transfer -> exactly one transfer is accepted during busy, and a new transfer is accepted only in the cycle after done.
REQ-036 Back-to-back: data_in_master=8'hFF then 8'h00 with start pulsed the cycle after done -> ss high for exactly 1 cycle, both words appear correctly on mosi, 2 done pulses.
REQ-037 rst pulsed after 3 rising edges -> next cycle ss=1, sclk_m=1, busy=0, no done pulse, data_out_master=0; a fresh transfer afterwards completes correctly.
REQ-038 CLK_DIV=1, DATA_WIDTH=8 -> sclk_m period 2 cycles, ss low for 17 cycles, loopback (miso=mosi) returns data_in_master unchanged.
